// File: rtl/memory_access_controller_if.sv
// Upstream request/response bus between a pipeline stage and memory_access_controller.
interface memory_access_controller_if;
    logic [1:0]  memory_control;
    logic [15:0] memory_address;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        stall;

    modport master (
        output memory_control, memory_address, write_data,
        input  read_data, stall
    );

    modport slave (
        input  memory_control, memory_address, write_data,
        output read_data, stall
    );
endinterface

// File: rtl/memory_access_controller.sv
// Sequences single SRAM reads/writes for one upstream stage, stalling it until DONE.
// Optional `UART_MMIO_EN maps UART data at 16'hBF00 and UART status at 16'hBF01.
module memory_access_controller (
    input  logic                      clk,
    input  logic                      rst,
    memory_access_controller_if.slave bus,
    output logic [15:0]               ram_addr,
    inout  wire  [15:0]               ram_data,
    output logic                      ram_ce_n,
    output logic                      ram_oe_n,
    output logic                      ram_we_n,
    output logic                      uart_rdn,
    output logic                      uart_wrn,
    input  logic                      uart_data_ready,
    input  logic                      uart_tbre,
    input  logic                      uart_tsre
);
    localparam logic [1:0] CTRL_READ  = 2'b01;
    localparam logic [1:0] CTRL_WRITE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_SAMPLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        TGT_SRAM,
        TGT_UART_DATA,
        TGT_UART_STATUS
    } target_t;

    state_t      state;
    target_t     target_q;
    target_t     target_d;
    logic [15:0] wdata_q;
    logic [15:0] read_data_q;
    logic [15:0] load_value;
    logic        drive_q;
    logic        rd_req;
    logic        wr_req;

    assign rd_req = (bus.memory_control == CTRL_READ);
    assign wr_req = (bus.memory_control == CTRL_WRITE);

    // Stall is combinational in IDLE so the upstream stage freezes in the same cycle it issues.
    assign bus.stall = !rst && (((state == IDLE) && (rd_req || wr_req)) ||
                                ((state != IDLE) && (state != DONE)));
    assign bus.read_data = read_data_q;
    assign ram_data      = drive_q ? wdata_q : 16'hzzzz;

`ifdef UART_MMIO_EN
    localparam logic [15:0] UART_DATA_ADDR   = 16'hBF00;
    localparam logic [15:0] UART_STATUS_ADDR = 16'hBF01;

    always_comb begin
        target_d = TGT_SRAM;
        if (bus.memory_address == UART_DATA_ADDR) begin
            target_d = TGT_UART_DATA;
        end else if (bus.memory_address == UART_STATUS_ADDR) begin
            target_d = TGT_UART_STATUS;
        end
    end

    always_comb begin
        load_value = ram_data;
        if (target_q == TGT_UART_DATA) begin
            load_value = {8'h00, ram_data[7:0]};
        end else if (target_q == TGT_UART_STATUS) begin
            load_value = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
        end
    end
`else
    logic unused_uart_status;

    assign target_d           = TGT_SRAM;
    assign load_value         = ram_data;
    assign uart_rdn           = 1'b1;
    assign uart_wrn           = 1'b1;
    assign unused_uart_status = uart_data_ready ^ uart_tbre ^ uart_tsre;
`endif

    // Every strobe and the data drive are registered from the state, so reset kills them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            target_q    <= TGT_SRAM;
            ram_addr    <= 16'hFFFF;
            wdata_q     <= 16'h0000;
            read_data_q <= 16'h0000;
            drive_q     <= 1'b0;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
`ifdef UART_MMIO_EN
            uart_rdn    <= 1'b1;
            uart_wrn    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        ram_addr <= bus.memory_address;
                        wdata_q  <= bus.write_data;
                        target_q <= target_d;
                        state    <= rd_req ? RD_SETUP : WR_SETUP;
                        if (target_d == TGT_SRAM) begin
                            ram_ce_n <= 1'b0;
                        end
                        if (rd_req && (target_d == TGT_SRAM)) begin
                            ram_oe_n <= 1'b0;
                        end
                        if (wr_req && (target_d != TGT_UART_STATUS)) begin
                            drive_q <= 1'b1;
                        end
`ifdef UART_MMIO_EN
                        if (rd_req && (target_d == TGT_UART_DATA)) begin
                            uart_rdn <= 1'b0;
                        end
`endif
                    end
                end
                RD_SETUP: begin
                    state <= RD_SAMPLE;
                end
                RD_SAMPLE: begin
                    read_data_q <= load_value;
                    ram_ce_n    <= 1'b1;
                    ram_oe_n    <= 1'b1;
`ifdef UART_MMIO_EN
                    uart_rdn    <= 1'b1;
`endif
                    state       <= DONE;
                end
                WR_SETUP: begin
                    if (target_q == TGT_SRAM) begin
                        ram_we_n <= 1'b0;
                    end
`ifdef UART_MMIO_EN
                    if (target_q == TGT_UART_DATA) begin
                        uart_wrn <= 1'b0;
                    end
`endif
                    state <= WR_STROBE;
                end
                WR_STROBE: begin
                    ram_we_n <= 1'b1;
`ifdef UART_MMIO_EN
                    uart_wrn <= 1'b1;
`endif
                    state    <= WR_HOLD;
                end
                WR_HOLD: begin
                    ram_ce_n <= 1'b1;
                    drive_q  <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access_controller.sv
// Bench for memory_access_controller: SRAM/UART models, vector table and a scoreboard
// of expected completions that is checked whenever the DUT reaches its DONE cycle.
module tb_memory_access_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ram_ce_n, ram_oe_n, ram_we_n;
    logic        uart_rdn, uart_wrn;
    logic        uart_data_ready, uart_tbre, uart_tsre;

    memory_access_controller_if bus ();

    memory_access_controller dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .ram_addr        (ram_addr),
        .ram_data        (ram_data),
        .ram_ce_n        (ram_ce_n),
        .ram_oe_n        (ram_oe_n),
        .ram_we_n        (ram_we_n),
        .uart_rdn        (uart_rdn),
        .uart_wrn        (uart_wrn),
        .uart_data_ready (uart_data_ready),
        .uart_tbre       (uart_tbre),
        .uart_tsre       (uart_tsre)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctrl;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          stall_cyc;
        int          oe_cyc;
        int          we_cyc;
        int          urd_cyc;
        int          uwr_cyc;
        logic        check_mem;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    vec_t exp_q[$];
    vec_t vecs[$];

    // SRAM model: preloaded on the first edge, written while ce_n and we_n are both low.
    logic [15:0] sram [0:65535];
    bit          sram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!sram_loaded) begin
            for (int i = 0; i < 65536; i++) sram[i] <= 16'h0000;
            sram[16'h1234] <= 16'hABCD;
            sram_loaded    <= 1'b1;
        end else if (!ram_ce_n && !ram_we_n) begin
            sram[ram_addr] <= ram_data;
        end
    end

    assign ram_data = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr] :
`ifdef UART_MMIO_EN
                      (!uart_rdn) ? 16'hEE5C :
`endif
                      16'hzzzz;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    int   stall_cnt = 0, oe_cnt = 0, we_cnt = 0, urd_cnt = 0, uwr_cnt = 0;
    logic prev_stall = 1'b0;
    logic overlap_seen = 1'b0;

    task automatic scoreboardCheck();
        vec_t e;
        if (exp_q.size() == 0) begin
            checkOutput("done_without_request", exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        if (e.ctrl == 2'b01) checkOutput("read_data", bus.read_data, e.rdata);
        if (e.check_mem) checkOutput("sram_content", sram[e.addr], e.wdata);
        checkOutput("stall_cycles", stall_cnt, e.stall_cyc);
        checkOutput("oe_low_cycles", oe_cnt, e.oe_cyc);
        checkOutput("we_low_cycles", we_cnt, e.we_cyc);
        checkOutput("uart_rdn_low_cycles", urd_cnt, e.urd_cyc);
        checkOutput("uart_wrn_low_cycles", uwr_cnt, e.uwr_cyc);
    endtask

    // A falling stall marks DONE: compare the oldest expected completion and restart counters.
    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0; oe_cnt = 0; we_cnt = 0; urd_cnt = 0; uwr_cnt = 0;
            prev_stall = 1'b0;
        end else begin
            if (!ram_oe_n && !ram_we_n) overlap_seen = 1'b1;
            if (prev_stall && !bus.stall) begin
                scoreboardCheck();
                stall_cnt = 0; oe_cnt = 0; we_cnt = 0; urd_cnt = 0; uwr_cnt = 0;
            end else begin
                if (bus.stall) stall_cnt++;
                if (!ram_oe_n) oe_cnt++;
                if (!ram_we_n) we_cnt++;
                if (!uart_rdn) urd_cnt++;
                if (!uart_wrn) uwr_cnt++;
            end
            prev_stall = bus.stall;
        end
    end

    function automatic vec_t mk(input logic [1:0] ctrl, input logic [15:0] addr, input logic [15:0] wdata,
                                input logic [15:0] rdata, input int st, input int oe, input int we,
                                input int urd, input int uwr, input logic chk);
        vec_t v;
        v.ctrl = ctrl; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.stall_cyc = st; v.oe_cyc = oe; v.we_cyc = we;
        v.urd_cyc = urd; v.uwr_cyc = uwr; v.check_mem = chk;
        return v;
    endfunction

    task automatic waitDone(input bit release_req);
        bit seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (!bus.stall) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("done_reached", seen, 1);
        if (release_req) bus.memory_control = 2'b00;
    endtask

    task automatic applyStimulus(input vec_t v, input bit release_req);
        bus.memory_control = v.ctrl;
        bus.memory_address = v.addr;
        bus.write_data     = v.wdata;
        exp_q.push_back(v);
        waitDone(release_req);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       we_seen;
        logic [4:0] strobes;

        vecs.push_back(mk(2'b01, 16'h1234, 16'h0000, 16'hABCD, 3, 2, 0, 0, 0, 1'b0));
        vecs.push_back(mk(2'b10, 16'h0040, 16'h5A5A, 16'h0000, 4, 0, 1, 0, 0, 1'b1));
        vecs.push_back(mk(2'b01, 16'h0040, 16'h0000, 16'h5A5A, 3, 2, 0, 0, 0, 1'b0));
        vecs.push_back(mk(2'b10, 16'hFFFF, 16'h0001, 16'h0000, 4, 0, 1, 0, 0, 1'b1));
        vecs.push_back(mk(2'b01, 16'hFFFF, 16'h0000, 16'h0001, 3, 2, 0, 0, 0, 1'b0));
        vecs.push_back(mk(2'b10, 16'h0000, 16'hFFFF, 16'h0000, 4, 0, 1, 0, 0, 1'b1));
        vecs.push_back(mk(2'b01, 16'h0000, 16'h0000, 16'hFFFF, 3, 2, 0, 0, 0, 1'b0));
`ifndef UART_MMIO_EN
        vecs.push_back(mk(2'b10, 16'hBF00, 16'h00C3, 16'h0000, 4, 0, 1, 0, 0, 1'b1));
        vecs.push_back(mk(2'b01, 16'hBF00, 16'h0000, 16'h00C3, 3, 2, 0, 0, 0, 1'b0));
        vecs.push_back(mk(2'b10, 16'hBF01, 16'h1357, 16'h0000, 4, 0, 1, 0, 0, 1'b1));
        vecs.push_back(mk(2'b01, 16'hBF01, 16'h0000, 16'h1357, 3, 2, 0, 0, 0, 1'b0));
`endif

        // Reset values, with a request pending to show stall stays low under reset.
        rst = 1'b1;
        uart_data_ready = 1'b0; uart_tbre = 1'b0; uart_tsre = 1'b0;
        bus.memory_control = 2'b01;
        bus.memory_address = 16'h0000;
        bus.write_data     = 16'h0000;
        #12;
        checkOutput("reset_ce_n", ram_ce_n, 1);
        checkOutput("reset_oe_n", ram_oe_n, 1);
        checkOutput("reset_we_n", ram_we_n, 1);
        checkOutput("reset_uart_rdn", uart_rdn, 1);
        checkOutput("reset_uart_wrn", uart_wrn, 1);
        checkOutput("reset_ram_addr", ram_addr, 16'hFFFF);
        checkOutput("reset_read_data", bus.read_data, 16'h0000);
        checkOutput("reset_stall", bus.stall, 0);
        bus.memory_control = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], 1'b1);
            @(posedge clk); #1;
        end

        // Back-to-back: the write is presented during DONE and must be taken on the first IDLE edge.
        applyStimulus(mk(2'b01, 16'h0040, 16'h0000, 16'h5A5A, 3, 2, 0, 0, 0, 1'b0), 1'b0);
        checkOutput("stall_in_done", bus.stall, 0);
        applyStimulus(mk(2'b10, 16'h0041, 16'hA5A5, 16'h0000, 4, 0, 1, 0, 0, 1'b1), 1'b1);
        @(posedge clk); #1;

        bus.memory_control = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            strobes = {ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn};
            checkOutput("code11_stall", bus.stall, 0);
            checkOutput("code11_strobes", strobes, 5'b11111);
        end
        @(posedge clk); #1;
        bus.memory_control = 2'b00;
        @(posedge clk); #1;

        // Inputs change right after acceptance; the latched write must complete unchanged.
        bus.memory_control = 2'b10;
        bus.memory_address = 16'h0100;
        bus.write_data     = 16'h1111;
        exp_q.push_back(mk(2'b10, 16'h0100, 16'h1111, 16'h0000, 4, 0, 1, 0, 0, 1'b1));
        @(posedge clk); #1;
        bus.memory_control = 2'b01;
        bus.memory_address = 16'h0200;
        bus.write_data     = 16'h2222;
        waitDone(1'b1);
        checkOutput("ignored_addr_untouched", sram[16'h0200], 16'h0000);
        @(posedge clk); #1;

        // Asynchronous reset in WR_SETUP abandons the write before any we_n pulse.
        bus.memory_control = 2'b10;
        bus.memory_address = 16'h0300;
        bus.write_data     = 16'h7777;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_ce_n", ram_ce_n, 1);
        checkOutput("async_rst_we_n", ram_we_n, 1);
        checkOutput("async_rst_oe_n", ram_oe_n, 1);
        checkOutput("async_rst_ram_addr", ram_addr, 16'hFFFF);
        checkOutput("async_rst_read_data", bus.read_data, 16'h0000);
        checkOutput("async_rst_stall", bus.stall, 0);
        bus.memory_control = 2'b00;
        we_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!ram_we_n) we_seen = 1'b1;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!ram_we_n) we_seen = 1'b1;
        end
        checkOutput("aborted_write_no_we", we_seen, 0);
        checkOutput("aborted_write_mem", sram[16'h0300], 16'h0000);
        @(posedge clk); #1;
        applyStimulus(mk(2'b01, 16'h1234, 16'h0000, 16'hABCD, 3, 2, 0, 0, 0, 1'b0), 1'b1);
        @(posedge clk); #1;

`ifdef UART_MMIO_EN
        uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b1;
        applyStimulus(mk(2'b01, 16'hBF01, 16'h0000, 16'h0003, 3, 0, 0, 0, 0, 1'b0), 1'b1);
        @(posedge clk); #1;
        uart_tsre = 1'b0;
        applyStimulus(mk(2'b01, 16'hBF01, 16'h0000, 16'h0002, 3, 0, 0, 0, 0, 1'b0), 1'b1);
        @(posedge clk); #1;
        applyStimulus(mk(2'b10, 16'hBF00, 16'h0042, 16'h0000, 4, 0, 0, 0, 1, 1'b0), 1'b1);
        checkOutput("uart_write_sram_untouched", sram[16'hBF00], 16'h0000);
        @(posedge clk); #1;
        applyStimulus(mk(2'b01, 16'hBF00, 16'h0000, 16'h005C, 3, 0, 0, 2, 0, 1'b0), 1'b1);
        @(posedge clk); #1;
        applyStimulus(mk(2'b10, 16'hBF01, 16'h0099, 16'h0000, 4, 0, 0, 0, 0, 1'b0), 1'b1);
        checkOutput("status_write_discarded", sram[16'hBF01], 16'h0000);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        checkOutput("oe_we_never_overlap", overlap_seen, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
